// File: rtl/decoder_select_arbiter.sv
// Round-robin owner selection for a shared 2-4 decoder, with a hold limit per ownership
// and a mandatory one-cycle all-off gap between successive owners.
module decoder_select_arbiter #(
    parameter int MAX_HOLD_CYCLES = 16,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic [3:0] Request_In,
    output logic       Grant_Valid_Out,
    output logic [1:0] Grant_Encoded_Out,
    output logic [3:0] Grant_Onehot_Out,
    output logic       Timeout_Out
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [COUNT_WIDTH-1:0] HOLD_LIMIT = COUNT_WIDTH'(MAX_HOLD_CYCLES);

    state_t                 state_reg, state_next;
    logic [1:0]             ptr_reg, ptr_next;
    logic [1:0]             owner_reg, owner_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;

    logic                   valid_reg, valid_next;
    logic [1:0]             enc_reg, enc_next;
    logic [3:0]             onehot_reg, onehot_next;
    logic                   timeout_reg, timeout_next;

    logic                   win_found;
    logic [1:0]             win_idx;
    logic [1:0]             cand;
    logic                   limit_hit;

    // Search upward from the pointer, wrapping 3->0; first active request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_reg;
        cand      = ptr_reg;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_reg + 2'(k);
            if (!win_found && Request_In[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign limit_hit = (MAX_HOLD_CYCLES != 0) && (count_reg == HOLD_LIMIT);

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_reg   <= IDLE;
            ptr_reg     <= 2'd0;
            owner_reg   <= 2'd0;
            count_reg   <= '0;
            valid_reg   <= 1'b0;
            enc_reg     <= 2'd0;
            onehot_reg  <= 4'd0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            owner_reg   <= owner_next;
            count_reg   <= count_next;
            valid_reg   <= valid_next;
            enc_reg     <= enc_next;
            onehot_reg  <= onehot_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE, GAP: begin
                if (win_found) begin
                    state_next = GRANT;
                    owner_next = win_idx;
                    count_next = COUNT_WIDTH'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                // A release on the limit cycle counts as a normal release.
                if (!Request_In[owner_reg] || limit_hit) begin
                    state_next = GAP;
                    ptr_next   = owner_reg + 2'd1;
                end else if (count_reg != '1) begin
                    count_next = count_reg + COUNT_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output values for the next cycle, registered alongside the state.
    always_comb begin
        valid_next   = (state_next == GRANT);
        enc_next     = owner_next;
        timeout_next = (state_reg == GRANT) && Request_In[owner_reg] && limit_hit;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
        assign onehot_next[gi] = valid_next && (owner_next == 2'(gi));
    end

    assign Grant_Valid_Out   = valid_reg;
    assign Grant_Encoded_Out = enc_reg;
    assign Grant_Onehot_Out  = onehot_reg;
    assign Timeout_Out       = timeout_reg;

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Bench for decoder_select_arbiter: one instance with a hold limit of 4, one unlimited.
// Per-cycle vectors go through a scoreboard queue; async reset is exercised by hand.
module tb_decoder_select_arbiter;

    logic       clk = 1'b0;
    logic       Reset_In = 1'b1;
    logic [3:0] req4 = 4'd0;
    logic [3:0] req0 = 4'd0;

    logic       v4, t4, v0, t0;
    logic [1:0] e4, e0;
    logic [3:0] o4, o0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         rst;    // reset both DUTs before applying this row
        bit         which;  // 0 = limited instance, 1 = unlimited instance
        logic [3:0] req;
        bit         v;
        logic [1:0] e;
        bit         t;
        bit         ce;     // compare encoded value on this row
        string      nm;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    decoder_select_arbiter #(.MAX_HOLD_CYCLES(4), .COUNT_WIDTH(8)) dut4 (
        .Clock_In(clk), .Reset_In(Reset_In), .Request_In(req4),
        .Grant_Valid_Out(v4), .Grant_Encoded_Out(e4),
        .Grant_Onehot_Out(o4), .Timeout_Out(t4)
    );

    decoder_select_arbiter #(.MAX_HOLD_CYCLES(0), .COUNT_WIDTH(8)) dut0 (
        .Clock_In(clk), .Reset_In(Reset_In), .Request_In(req0),
        .Grant_Valid_Out(v0), .Grant_Encoded_Out(e0),
        .Grant_Onehot_Out(o0), .Timeout_Out(t0)
    );

    function automatic vec_t mk(bit rst, bit which, logic [3:0] req, bit v,
                                logic [1:0] e, bit t, bit ce, string nm);
        vec_t x;
        x.rst = rst; x.which = which; x.req = req; x.v = v;
        x.e = e; x.t = t; x.ce = ce; x.nm = nm;
        return x;
    endfunction

    task automatic check_out(vec_t x);
        logic       v, t;
        logic [1:0] e;
        logic [3:0] oh, exp_oh;
        bit         bad;
        v  = x.which ? v0 : v4;
        t  = x.which ? t0 : t4;
        e  = x.which ? e0 : e4;
        oh = x.which ? o0 : o4;
        exp_oh = x.v ? (4'b0001 << x.e) : 4'b0000;
        bad = (v !== x.v) || (oh !== exp_oh) || (t !== x.t) || (x.ce && (e !== x.e));
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s: got v=%0b enc=%0d oh=%b to=%0b, want v=%0b enc=%0d%s oh=%b to=%0b",
                     x.nm, v, e, oh, t, x.v, x.e, x.ce ? "" : "(dc)", exp_oh, x.t);
        end else begin
            $display("ok   %s: v=%0b enc=%0d oh=%b to=%0b", x.nm, v, e, oh, t);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req4 = 4'd0;
        req0 = 4'd0;
        Reset_In = 1'b1;
        @(negedge clk);
        Reset_In = 1'b0;
    endtask

    // Drive on the falling edge, push the expectation, compare just after the rising edge.
    task automatic run_vec(vec_t x);
        vec_t got;
        if (x.rst) do_reset();
        @(negedge clk);
        if (x.which) req0 = x.req; else req4 = x.req;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_out(got);
    endtask

    initial begin
        // Single release with a pointer check afterwards.
        vecs.push_back(mk(1, 0, 4'b0010, 1, 2'd1, 0, 1, "t1 grant c1"));
        vecs.push_back(mk(0, 0, 4'b0010, 1, 2'd1, 0, 1, "t1 grant c2"));
        vecs.push_back(mk(0, 0, 4'b0010, 1, 2'd1, 0, 1, "t1 grant c3"));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 2'd1, 0, 1, "t1 gap"));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 2'd0, 0, 0, "t1 idle"));
        vecs.push_back(mk(0, 0, 4'b0101, 1, 2'd2, 0, 1, "t1 ptr2 winner"));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 2'd2, 0, 1, "t1 ptr2 gap"));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 2'd0, 0, 0, "t1 ptr2 idle"));
        // All four requesting: rotating owners, timeout in every gap.
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 4; c++)
                vecs.push_back(mk(o == 0 && c == 0, 0, 4'b1111, 1, 2'(o % 4), 0, 1,
                                  $sformatf("t2 own%0d c%0d", o % 4, c + 1)));
            if (o < 4)
                vecs.push_back(mk(0, 0, 4'b1111, 0, 2'(o % 4), 1, 1,
                                  $sformatf("t2 gap after %0d", o % 4)));
        end
        vecs.push_back(mk(0, 0, 4'b0000, 0, 2'd0, 0, 1, "t2 release gap"));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 2'd0, 0, 0, "t2 idle"));
        // Lone requester is re-granted after each timeout gap.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++)
                vecs.push_back(mk(r == 0 && c == 0, 0, 4'b0100, 1, 2'd2, 0, 1,
                                  $sformatf("t3 round%0d c%0d", r, c + 1)));
            if (r < 2)
                vecs.push_back(mk(0, 0, 4'b0100, 0, 2'd2, 1, 1, $sformatf("t3 gap%0d", r)));
        end
        vecs.push_back(mk(0, 0, 4'b0000, 0, 2'd2, 0, 1, "t3 release gap"));
        // Release on the limit cycle: no timeout, pointer moves to 2.
        for (int c = 0; c < 4; c++)
            vecs.push_back(mk(c == 0, 0, 4'b0010, 1, 2'd1, 0, 1, $sformatf("t4 c%0d", c + 1)));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 2'd1, 0, 1, "t4 drop at limit"));
        vecs.push_back(mk(0, 0, 4'b0110, 1, 2'd2, 0, 1, "t4 ptr2 winner"));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 2'd2, 0, 1, "t4 gap"));

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        check_out(mk(0, 0, 4'b0000, 0, 2'd0, 0, 1, "reset dut4"));
        check_out(mk(0, 1, 4'b0000, 0, 2'd0, 0, 1, "reset dut0"));
        @(negedge clk);
        Reset_In = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a grant.
        run_vec(mk(1, 0, 4'b0010, 1, 2'd1, 0, 1, "t5 grant"));
        @(negedge clk);
        #2 Reset_In = 1'b1;
        #1 check_out(mk(0, 0, 4'b0010, 0, 2'd0, 0, 1, "t5 async reset"));
        @(negedge clk);
        Reset_In = 1'b0;
        req4 = 4'b0000;
        run_vec(mk(0, 0, 4'b1000, 1, 2'd3, 0, 1, "t5 after reset"));
        run_vec(mk(0, 0, 4'b1010, 1, 2'd3, 0, 1, "t5 hold owner3"));

        // Unlimited hold: never revoked.
        for (int c = 0; c < 300; c++)
            run_vec(mk(c == 0, 1, 4'b0001, 1, 2'd0, 0, 1, $sformatf("t6 c%0d", c + 1)));
        run_vec(mk(0, 1, 4'b0000, 0, 2'd0, 0, 1, "t6 release gap"));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
